// File: rtl/pat_pkg.sv
// Shared field layout and phase encoding for the pattern phase driver.
// Field offsets after the P block depend on the tweak count, so they are functions.
package pat_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DEAD = 3'd1,
      HIGH = 3'd2,
      LOW  = 3'd3
   } phase_t;

   localparam int unsigned PDRIVE      = 0;
   localparam int unsigned NDRIVE      = 1;
   localparam int unsigned PTWEAKSENSE = 2;
   localparam int unsigned PTWEAKDELAY = 3;
   localparam int unsigned PTWEAK0     = 4;

   function automatic int unsigned ntweaksense(int unsigned no_tweaks);
      return 4 + no_tweaks;
   endfunction

   function automatic int unsigned ntweakdelay(int unsigned no_tweaks);
      return 5 + no_tweaks;
   endfunction

   function automatic int unsigned ntweak0(int unsigned no_tweaks);
      return 6 + no_tweaks;
   endfunction

   function automatic int unsigned nfields(int unsigned no_tweaks);
      return 2 + 2 * (2 + no_tweaks);
   endfunction

endpackage

// File: rtl/pattern_phase_driver_if.sv
// Field write / commit / readback port between the pat core (master) and the phase driver (slave).
interface pattern_phase_driver_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 5
);
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_err;
   logic             commit_req;
   logic             commit_pending;
   logic             commit_ack;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output wr_en, wr_addr, wr_data, commit_req, rd_addr,
      input  wr_err, commit_pending, commit_ack, rd_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit_req, rd_addr,
      output wr_err, commit_pending, commit_ack, rd_data
   );
endinterface

// File: rtl/pattern_field_bank.sv
// Double-buffered field bank: shadow written by the core, copied whole into active on a commit edge.
// view presents the active bank as it will stand after this clock, so drive muxing sees a commit at once.
module pattern_field_bank
   import pat_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NFIELDS = 22,
   parameter int unsigned AW      = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 edge_det,
   pattern_phase_driver_if.slave bus,
   output logic [WIDTH-1:0]     view [NFIELDS]
);
   localparam logic [AW:0] NF = (AW + 1)'(NFIELDS);

   logic [WIDTH-1:0] shadow [NFIELDS];
   logic [WIDTH-1:0] active [NFIELDS];
   logic             swap;
   logic             wr_in_range;
   logic             rd_in_range;

   assign swap        = edge_det && bus.commit_pending;
   assign wr_in_range = {1'b0, bus.wr_addr} < NF;
   assign rd_in_range = {1'b0, bus.rd_addr} < NF;

   always_comb begin
      for (int unsigned i = 0; i < NFIELDS; i++) begin
         view[i] = swap ? shadow[i] : active[i];
      end
   end

   // Copy reads shadow before this cycle's write, so a same-cycle write lands in shadow only.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NFIELDS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         bus.commit_pending <= 1'b0;
         bus.commit_ack     <= 1'b0;
         bus.wr_err         <= 1'b0;
         bus.rd_data        <= '0;
      end else begin
         if (swap) begin
            for (int unsigned i = 0; i < NFIELDS; i++) begin
               active[i] <= shadow[i];
            end
         end
         if (bus.wr_en && wr_in_range) begin
            shadow[bus.wr_addr] <= bus.wr_data;
         end
         bus.commit_pending <= swap ? bus.commit_req : (bus.commit_pending | bus.commit_req);
         bus.commit_ack     <= swap;
         bus.wr_err         <= bus.wr_en && !wr_in_range;
         bus.rd_data        <= rd_in_range ? active[bus.rd_addr] : '0;
      end
   end
endmodule

// File: rtl/pattern_phase_driver.sv
// Phase sequencer: pwm edge detect, dead-time FSM, buffer_select strobe and registered driver outputs.
// Output registers are loaded from the next state so every output lands on the clock after the edge cycle.
module pattern_phase_driver
   import pat_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned NO_TWEAKS   = 8,
   parameter int unsigned NO_BUFS     = 8,
   parameter int unsigned DEAD_CYCLES = 2,
   parameter int unsigned AW          = $clog2(nfields(NO_TWEAKS))
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pwm,
   pattern_phase_driver_if.slave         bus,
   output logic [NO_BUFS-1:0]            buffer_select,
   output logic [2:0]                    phase,
   output logic [WIDTH-1:0]              p_drive,
   output logic [WIDTH-1:0]              n_drive,
   output logic [WIDTH-1:0]              tweak_sense,
   output logic [WIDTH-1:0]              tweak_delay,
   output logic [NO_TWEAKS*WIDTH-1:0]    tweak_drive
);
   localparam int unsigned NFIELDS = nfields(NO_TWEAKS);
   localparam int unsigned NTS     = ntweaksense(NO_TWEAKS);
   localparam int unsigned NTD     = ntweakdelay(NO_TWEAKS);
   localparam int unsigned NT0     = ntweak0(NO_TWEAKS);
   localparam int unsigned CW      = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEAD_CYCLES - 1);

   phase_t                     state, next_state, target;
   logic                       pwm_prev, edge_det;
   logic [CW-1:0]              dead_cnt, cnt_nx;
   logic [WIDTH-1:0]           view [NFIELDS];
   logic [WIDTH-1:0]           p_nx, n_nx, s_nx, d_nx;
   logic [NO_TWEAKS*WIDTH-1:0] t_nx;
   logic [NO_BUFS-1:0]         bs_nx;

   assign edge_det = pwm != pwm_prev;
   assign phase    = state;

   pattern_field_bank #(
      .WIDTH   (WIDTH),
      .NFIELDS (NFIELDS),
      .AW      (AW)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .edge_det (edge_det),
      .bus      (bus),
      .view     (view)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dead_cnt <= '0;
         pwm_prev <= pwm;
      end else begin
         state    <= next_state;
         dead_cnt <= cnt_nx;
         pwm_prev <= pwm;
      end
   end

   // In DEAD without an edge pwm equals pwm_prev, so pwm picks the target in every case.
   always_comb begin
      next_state = state;
      cnt_nx     = dead_cnt;
      target     = pwm ? HIGH : LOW;
      case (state)
         IDLE, HIGH, LOW: begin
            if (edge_det) begin
               cnt_nx     = '0;
               next_state = (DEAD_CYCLES == 0) ? target : DEAD;
            end
         end
         DEAD: begin
            if (edge_det)                cnt_nx     = '0;
            else if (dead_cnt == CNT_LAST) next_state = target;
            else                         cnt_nx     = dead_cnt + 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      p_nx  = '1;
      n_nx  = '0;
      s_nx  = '0;
      d_nx  = '0;
      t_nx  = '0;
      bs_nx = '0;
      case (next_state)
         HIGH: begin
            p_nx = view[PDRIVE];
            s_nx = view[PTWEAKSENSE];
            d_nx = view[PTWEAKDELAY];
            for (int unsigned k = 0; k < NO_TWEAKS; k++) t_nx[k*WIDTH +: WIDTH] = view[PTWEAK0 + k];
         end
         LOW: begin
            n_nx = view[NDRIVE];
            s_nx = view[NTS];
            d_nx = view[NTD];
            for (int unsigned k = 0; k < NO_TWEAKS; k++) t_nx[k*WIDTH +: WIDTH] = view[NT0 + k];
         end
         default: ;
      endcase
      if (next_state == HIGH || next_state == LOW) begin
         if (next_state != state)            bs_nx = NO_BUFS'(1);
         else if (buffer_select[NO_BUFS-1])  bs_nx = buffer_select;
         else                                bs_nx = buffer_select << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_drive       <= '1;
         n_drive       <= '0;
         tweak_sense   <= '0;
         tweak_delay   <= '0;
         tweak_drive   <= '0;
         buffer_select <= '0;
      end else begin
         p_drive       <= p_nx;
         n_drive       <= n_nx;
         tweak_sense   <= s_nx;
         tweak_delay   <= d_nx;
         tweak_drive   <= t_nx;
         buffer_select <= bs_nx;
      end
   end
endmodule
